hex_share_arbiter: RTL and testbench

HEX_SHARE_ARBITER -- requirements
Module: hex_share_arbiter

---
 rtl/hex_share_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_hex_share_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_share_arbiter.sv
// Round-robin arbiter that shares six seven-segment digits between N_REQ
// requesters. The owner keeps the display for at least DWELL cycles, may update
// its digits live while it holds its request, and then yields to the next
// requester in rotation with no idle gap between owners.
//
// state | meaning
// IDLE  | no owner; gnt is zero, display holds the last latched data
// OWN   | owner valid, gnt[owner]=1; dwell counter running or expired

module hex_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int DWELL = 25000000
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic [N_REQ-1:0]           req,
    input  logic [24*N_REQ-1:0]        value,
    input  logic [6*N_REQ-1:0]         blank,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [6:0]                 HEX0,
    output logic [6:0]                 HEX1,
    output logic [6:0]                 HEX2,
    output logic [6:0]                 HEX3,
    output logic [6:0]                 HEX4,
    output logic [6:0]                 HEX5
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
    localparam logic [OW-1:0] LAST_RESET = OW'(N_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [OW-1:0]     owner_n;
    logic [OW-1:0]     last_owner;
    logic [OW-1:0]     last_n;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_n;
    logic [N_REQ-1:0]  ack_n;

    logic              found;
    logic [OW-1:0]     winner;
    logic [OW-1:0]     cand;

    logic              load;
    logic [OW-1:0]     load_idx;

    logic [23:0]       disp_value;
    logic [5:0]        disp_blank;
    logic [6:0]        hex_seg [6];

    logic [23:0]       value_arr [N_REQ];
    logic [5:0]        blank_arr [N_REQ];

    // Split the flat requester buses into per-requester words.
    for (genvar g = 0; g < N_REQ; g++) begin : g_split
        assign value_arr[g] = value[24*g +: 24];
        assign blank_arr[g] = blank[6*g +: 6];
    end

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Round-robin search starting just after the last owner, so the current
    // owner is always the lowest-priority candidate.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = OW'((int'(last_owner) + i) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state, dwell counter, ack and display-load decisions.
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        last_n   = last_owner;
        count_n  = count;
        ack_n    = '0;
        load     = 1'b0;
        load_idx = owner;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n       = OWN;
                    owner_n       = winner;
                    last_n        = winner;
                    count_n       = DWELL_LOAD;
                    ack_n[winner] = 1'b1;
                    load          = 1'b1;
                    load_idx      = winner;
                end
            end
            OWN: begin
                if (count != '0) begin
                    count_n = count - CW'(1);
                    if (req[owner]) begin
                        load     = 1'b1;
                        load_idx = owner;
                    end
                end else if (!found) begin
                    state_n = IDLE;
                end else if (winner != owner) begin
                    owner_n       = winner;
                    last_n        = winner;
                    count_n       = DWELL_LOAD;
                    ack_n[winner] = 1'b1;
                    load          = 1'b1;
                    load_idx      = winner;
                end else begin
                    // Only the owner is asking: it keeps the display and
                    // continues to update it, with the counter parked at zero.
                    load     = 1'b1;
                    load_idx = owner;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_RESET;
            count      <= '0;
            ack        <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
            count      <= count_n;
            ack        <= ack_n;
        end
    end

    // Display latch: only the owner's (or incoming winner's) data is captured.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            disp_value <= '0;
            disp_blank <= '1;
        end else if (load) begin
            disp_value <= value_arr[load_idx];
            disp_blank <= blank_arr[load_idx];
        end
    end

    // One-hot grant decoded from the registered state and owner.
    always_comb begin
        gnt = '0;
        if (state == OWN) begin
            gnt[owner] = 1'b1;
        end
    end

    assign busy = (count != '0);

    // Per-digit segment decode of the latched display data.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            hex_seg[k] = disp_blank[k] ? 7'h7F : seg7(disp_value[4*k +: 4]);
        end
    end

    assign HEX0 = hex_seg[0];
    assign HEX1 = hex_seg[1];
    assign HEX2 = hex_seg[2];
    assign HEX3 = hex_seg[3];
    assign HEX4 = hex_seg[4];
    assign HEX5 = hex_seg[5];

endmodule

// File: tb/tb_hex_share_arbiter.sv
// Directed bench for hex_share_arbiter (N_REQ=4, DWELL=4). Grant events are
// queued by the stimulus and checked by an independent monitor on each ack.

module tb_hex_share_arbiter;

    logic        clk;
    logic        RESET;
    logic [3:0]  req;
    logic [95:0] value;
    logic [23:0] blank;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [41:0] hex_all;

    logic [23:0] val [4];
    logic [5:0]  blk [4];

    typedef struct {
        logic [3:0]  ack;
        logic [1:0]  owner;
        logic [41:0] hex;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    assign value   = {val[3], val[2], val[1], val[0]};
    assign blank   = {blk[3], blk[2], blk[1], blk[0]};
    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    hex_share_arbiter #(.N_REQ(4), .DWELL(4)) dut (
        .CLOCK_50 (clk),
        .RESET    (RESET),
        .req      (req),
        .value    (value),
        .blank    (blank),
        .gnt      (gnt),
        .ack      (ack),
        .owner    (owner),
        .busy     (busy),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    function automatic logic [41:0] disp(input logic [23:0] v, input logic [5:0] b);
        logic [41:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            r[7*k +: 7] = b[k] ? 7'h7F : seg(v[4*k +: 4]);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_grant(input logic [1:0] idx, input logic [23:0] v, input logic [5:0] b);
        exp_t e;
        e.ack   = 4'b0001 << idx;
        e.owner = idx;
        e.hex   = disp(v, b);
        exp_q.push_back(e);
    endtask

    // Monitor: every ack pulse must match the next queued grant.
    always @(negedge clk) begin
        if (!RESET && ack != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'(ack), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("grant_ack",   64'(ack),     64'(mon_e.ack));
                check("grant_gnt",   64'(gnt),     64'(mon_e.ack));
                check("grant_owner", 64'(owner),   64'(mon_e.owner));
                check("grant_hex",   64'(hex_all), 64'(mon_e.hex));
            end
        end
    end

    initial begin
        RESET  = 1'b1;
        req    = 4'b0000;
        val[0] = 24'h123456;
        val[1] = 24'h13579B;
        val[2] = 24'h789ABC;
        val[3] = 24'h000000;
        blk[0] = 6'b000000;
        blk[1] = 6'b000000;
        blk[2] = 6'b110000;
        blk[3] = 6'b000000;

        repeat (3) @(negedge clk);
        check("rst_gnt",   64'(gnt),     64'(0));
        check("rst_hex",   64'(hex_all), 64'({6{7'h7F}}));
        check("rst_owner", 64'(owner),   64'(0));
        check("rst_busy",  64'(busy),    64'(0));
        RESET = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_gnt",  64'(gnt),     64'(0));
            check("idle_busy", 64'(busy),    64'(0));
            check("idle_hex",  64'(hex_all), 64'({6{7'h7F}}));
        end

        // Requesters 0 and 2 together: 0 first, then 2, then back to 0.
        req = 4'b0101;
        push_grant(2'd0, 24'h123456, 6'b000000);
        push_grant(2'd2, 24'h789ABC, 6'b110000);
        push_grant(2'd0, 24'h123456, 6'b000000);
        @(negedge clk);
        check("own0_gnt",  64'(gnt),  64'(4'b0001));
        check("own0_busy1", 64'(busy), 64'(1));
        @(negedge clk);
        check("own0_busy2", 64'(busy), 64'(1));
        @(negedge clk);
        check("own0_busy3", 64'(busy), 64'(1));
        @(negedge clk);
        check("own0_busy_low", 64'(busy), 64'(0));
        check("own0_gnt_hold", 64'(gnt),  64'(4'b0001));
        @(negedge clk);
        check("own2_gnt", 64'(gnt), 64'(4'b0100));
        repeat (4) @(negedge clk);
        check("back0_gnt", 64'(gnt), 64'(4'b0001));

        // Owner 0 drops its request early and changes its value: display frozen.
        val[0] = 24'h000000;
        req    = 4'b0000;
        @(negedge clk);
        check("freeze_hex",  64'(hex_all), 64'(disp(24'h123456, 6'b000000)));
        check("freeze_busy", 64'(busy),    64'(1));
        @(negedge clk);
        @(negedge clk);
        check("freeze_gnt_hold", 64'(gnt),  64'(4'b0001));
        check("freeze_busy_low", 64'(busy), 64'(0));
        @(negedge clk);
        check("release_gnt",   64'(gnt),     64'(0));
        check("release_hex",   64'(hex_all), 64'(disp(24'h123456, 6'b000000)));
        check("release_owner", 64'(owner),   64'(0));

        // Requester 1 takes over and updates its digits live.
        req = 4'b0010;
        push_grant(2'd1, 24'h13579B, 6'b000000);
        @(negedge clk);
        check("live_before", 64'(hex_all), 64'(disp(24'h13579B, 6'b000000)));
        val[1] = 24'hABCDEF;
        @(negedge clk);
        check("live_value", 64'(hex_all), 64'(disp(24'hABCDEF, 6'b000000)));
        check("live_gnt",   64'(gnt),     64'(4'b0010));
        blk[1] = 6'b100001;
        @(negedge clk);
        check("live_blank", 64'(hex_all), 64'(disp(24'hABCDEF, 6'b100001)));
        @(negedge clk);
        check("solo_busy_low", 64'(busy), 64'(0));
        @(negedge clk);
        check("solo_gnt",   64'(gnt),   64'(4'b0010));
        check("solo_owner", 64'(owner), 64'(1));
        check("solo_busy",  64'(busy),  64'(0));

        // Requester 3 joins after dwell expiry: immediate transfer.
        val[3] = 24'hFEDCBA;
        req    = 4'b1010;
        push_grant(2'd3, 24'hFEDCBA, 6'b000000);
        @(negedge clk);
        check("xfer3_gnt", 64'(gnt), 64'(4'b1000));

        // Reset mid-ownership.
        @(negedge clk);
        RESET = 1'b1;
        #1;
        check("midrst_gnt",   64'(gnt),     64'(0));
        check("midrst_hex",   64'(hex_all), 64'({6{7'h7F}}));
        check("midrst_busy",  64'(busy),    64'(0));
        check("midrst_owner", 64'(owner),   64'(0));
        check("midrst_ack",   64'(ack),     64'(0));
        @(negedge clk);
        RESET = 1'b0;
        req   = 4'b1000;
        push_grant(2'd3, 24'hFEDCBA, 6'b000000);
        @(negedge clk);
        check("postrst_owner", 64'(owner), 64'(3));
        req = 4'b0000;
        repeat (5) @(negedge clk);
        check("end_gnt",   64'(gnt),     64'(0));
        check("end_owner", 64'(owner),   64'(3));
        check("end_busy",  64'(busy),    64'(0));
        check("end_hex",   64'(hex_all), 64'(disp(24'hFEDCBA, 6'b000000)));
        check("grants_pending", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
